// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one data-memory transaction per MEM instruction, stalling until the response.
// Optional bus-wait timeout is built when LSU_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_flush,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_fault,
  output logic [1:0]  lsu_fault_cause,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic        access, misaligned, accept, mis_fault, kill_now, timeout;
  logic        done_resp, done_timeout;
  logic [3:0]  new_strb;
  logic [31:0] new_wdata, shifted, load_data;

  assign access     = req_ren | req_wen;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign accept     = access && !req_flush && !misaligned;
  assign mis_fault  = (state_q == IDLE) && access && !req_flush && misaligned;
  assign kill_now   = kill_q | req_flush;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the bus is outstanding, so it is zero on every entry to REQ.
  always_comb begin
    cnt_d = '0;
    if ((state_q == REQ) || (state_q == WAIT)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] timeout_limit_unused;
  assign timeout_limit_unused = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    new_strb  = 4'b1111;
    new_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        new_strb  = 4'b0001 << req_addr[1:0];
        new_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        new_strb  = 4'b0011 << req_addr[1:0];
        new_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = {24'd0, shifted[7:0]};
      2'b01:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    off_d        = off_q;
    size_d       = size_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    cause_d      = cause_q;
    done_resp    = 1'b0;
    done_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          kill_d  = 1'b0;
          off_d   = req_addr[1:0];
          size_d  = req_size;
          wen_d   = req_wen;
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = new_wdata;
          strb_d  = new_strb;
        end
      end
      REQ: begin
        kill_d = kill_now;
        if (dmem_ready && dmem_rvalid) done_resp = 1'b1;
        else if (dmem_ready)           state_d = WAIT;
        else if (timeout)              done_timeout = 1'b1;
      end
      WAIT: begin
        kill_d = kill_now;
        if (dmem_rvalid)  done_resp = 1'b1;
        else if (timeout) done_timeout = 1'b1;
      end
      DONE:    state_d = IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A killed instruction drains silently: no data or fault update reaches WB.
    if (done_resp || done_timeout) begin
      if (kill_now) begin
        state_d = DRAIN;
      end else begin
        state_d = DONE;
        fault_d = done_timeout;
        cause_d = done_timeout ? 2'b10 : 2'b00;
        if (done_timeout) rdata_d = 32'd0;
        else if (!wen_q)  rdata_d = load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign lsu_stall       = ((state_q == IDLE) && accept) || (state_q == REQ) ||
                           (state_q == WAIT) || (state_q == DRAIN);
  assign lsu_rdata       = rdata_q;
  assign lsu_fault       = mis_fault | fault_q;
  assign lsu_fault_cause = mis_fault ? 2'b01 : cause_q;
  assign dmem_valid      = (state_q == REQ);
  assign dmem_addr       = addr_q;
  assign dmem_wen        = wen_q;
  assign dmem_wdata      = wdata_q;
  assign dmem_wstrb      = strb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a per-cycle vector table plus hand sequences for
// flush/drain, bus-wait (timeout when LSU_TIMEOUT_EN is defined) and asynchronous reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ren = 1'b0, req_wen = 1'b0, req_flush = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        lsu_stall, lsu_fault, dmem_valid, dmem_wen;
  logic [31:0] lsu_rdata, dmem_addr, dmem_wdata;
  logic [1:0]  lsu_fault_cause;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_stall, e_valid, chk_bus, e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_fault;
    logic [1:0]  e_cause;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_flush(req_flush),
    .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault),
    .lsu_fault_cause(lsu_fault_cause),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(
    input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [1:0] size, input logic ready, input logic rvalid, input logic [31:0] rdata,
    input logic e_stall, input logic e_valid, input logic chk_bus, input logic e_wen,
    input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_strb,
    input logic e_fault, input logic [1:0] e_cause, input logic [31:0] e_rdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size;
    v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
    v.e_stall = e_stall; v.e_valid = e_valid; v.chk_bus = chk_bus; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb;
    v.e_fault = e_fault; v.e_cause = e_cause; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_ren = v.ren; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_flush = 1'b0;
    dmem_ready = v.ready; dmem_rvalid = v.rvalid; dmem_rdata = v.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    req_ren = 0; req_wen = 0; req_flush = 0; req_addr = '0; req_wdata = '0; req_size = '0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  initial begin
    // ren wen addr wdata size | ready rvalid rdata | stall valid chk wen addr wdata strb | fault cause rdata
    vecs.push_back(mkv(0,0,32'h0,32'h0,2'd0, 0,0,32'h0, 0,0,1,0,32'h0,32'h0,4'h0, 0,2'd0,32'h0));
    vecs.push_back(mkv(1,0,32'h1000,32'h0,2'd2, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h0));
    vecs.push_back(mkv(1,0,32'h1000,32'h0,2'd2, 1,1,32'hDEADBEEF, 1,1,1,0,32'h1000,32'h0,4'hF, 0,2'd0,32'h0));
    vecs.push_back(mkv(1,0,32'h1000,32'h0,2'd2, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 1,0,32'h0, 1,1,1,0,32'h1000,32'h0,4'h8, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 0,1,32'h80AABBCC, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hDEADBEEF));
    vecs.push_back(mkv(1,0,32'h1003,32'h0,2'd0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 0,0,32'h0, 1,1,1,1,32'h2000,32'h12341234,4'hC, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 0,0,32'h0, 1,1,1,1,32'h2000,32'h12341234,4'hC, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 1,0,32'h0, 1,1,1,1,32'h2000,32'h12341234,4'hC, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 0,1,32'h0, 1,0,1,1,32'h2000,32'h12341234,4'hC, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2002,32'h1234,2'd1, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h80));
    vecs.push_back(mkv(1,0,32'h3001,32'h0,2'd2, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 1,2'd1,32'h80));
    vecs.push_back(mkv(0,0,32'h0,32'h0,2'd0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h80));
    vecs.push_back(mkv(0,1,32'h2001,32'h0,2'd1, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 1,2'd1,32'h80));
    vecs.push_back(mkv(1,0,32'h4001,32'h0,2'd0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h80));
    vecs.push_back(mkv(1,0,32'h4001,32'h0,2'd0, 1,1,32'h12345678, 1,1,1,0,32'h4000,32'h0,4'h2, 0,2'd0,32'h80));
    vecs.push_back(mkv(1,0,32'h4001,32'h0,2'd0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h56));
    vecs.push_back(mkv(1,0,32'h5002,32'h0,2'd1, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'h56));
    vecs.push_back(mkv(1,0,32'h5002,32'h0,2'd1, 1,1,32'hCAFEF00D, 1,1,1,0,32'h5000,32'h0,4'hC, 0,2'd0,32'h56));
    vecs.push_back(mkv(1,0,32'h5002,32'h0,2'd1, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h6001,32'hA5,2'd0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h6001,32'hA5,2'd0, 1,1,32'h0, 1,1,1,1,32'h6000,32'hA5A5A5A5,4'h2, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h6001,32'hA5,2'd0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h7004,32'h87654321,2'd3, 0,0,32'h0, 1,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h7004,32'h87654321,2'd3, 1,1,32'h0, 1,1,1,1,32'h7004,32'h87654321,4'hF, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(0,1,32'h7004,32'h87654321,2'd3, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));
    vecs.push_back(mkv(1,0,32'h7006,32'h0,2'd3, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 1,2'd1,32'hCAFE));
    vecs.push_back(mkv(0,0,32'h0,32'h0,2'd0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0, 0,2'd0,32'hCAFE));

    $display("[TB] starting, %0d table vectors", vecs.size());
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d stall", i), 32'(lsu_stall), 32'(vecs[i].e_stall));
      checkOutput($sformatf("v%0d valid", i), 32'(dmem_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d fault", i), 32'(lsu_fault), 32'(vecs[i].e_fault));
      checkOutput($sformatf("v%0d cause", i), 32'(lsu_fault_cause), 32'(vecs[i].e_cause));
      checkOutput($sformatf("v%0d rdata", i), lsu_rdata, vecs[i].e_rdata);
      if (vecs[i].chk_bus) begin
        checkOutput($sformatf("v%0d dmem_wen", i), 32'(dmem_wen), 32'(vecs[i].e_wen));
        checkOutput($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].e_addr);
        checkOutput($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
        checkOutput($sformatf("v%0d dmem_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_strb));
      end
      cyc();
    end

    // Flush while waiting for the response: drain one cycle, load data untouched.
    idleInputs();
    req_ren = 1; req_addr = 32'h7000; req_size = 2'd2;
    @(negedge clk); checkOutput("flush idle stall", 32'(lsu_stall), 32'd1);
    cyc(); dmem_ready = 1;
    @(negedge clk); checkOutput("flush req valid", 32'(dmem_valid), 32'd1);
    cyc(); dmem_ready = 0; req_flush = 1; req_ren = 0;
    @(negedge clk); checkOutput("flush wait stall", 32'(lsu_stall), 32'd1);
    cyc(); req_flush = 0;
    @(negedge clk); checkOutput("flush wait2 stall", 32'(lsu_stall), 32'd1);
    cyc(); dmem_rvalid = 1; dmem_rdata = 32'h11111111;
    @(negedge clk); checkOutput("flush resp stall", 32'(lsu_stall), 32'd1);
    cyc(); dmem_rvalid = 0; dmem_rdata = '0;
    @(negedge clk);
    checkOutput("drain stall", 32'(lsu_stall), 32'd1);
    checkOutput("drain rdata", lsu_rdata, 32'hCAFE);
    checkOutput("drain fault", 32'(lsu_fault), 32'd0);
    cyc();
    @(negedge clk);
    checkOutput("post-drain stall", 32'(lsu_stall), 32'd0);
    checkOutput("post-drain rdata", lsu_rdata, 32'hCAFE);
    cyc();

`ifdef LSU_TIMEOUT_EN
    // Ready held low: with a limit of 8 the access completes with a timeout in cycle 9.
    req_ren = 1; req_addr = 32'h9000; req_size = 2'd2;
    @(negedge clk); checkOutput("to idle stall", 32'(lsu_stall), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      @(negedge clk);
      checkOutput($sformatf("to c%0d valid", k), 32'(dmem_valid), 32'd1);
      checkOutput($sformatf("to c%0d stall", k), 32'(lsu_stall), 32'd1);
    end
    cyc();
    @(negedge clk);
    checkOutput("to done stall", 32'(lsu_stall), 32'd0);
    checkOutput("to done valid", 32'(dmem_valid), 32'd0);
    checkOutput("to done fault", 32'(lsu_fault), 32'd1);
    checkOutput("to done cause", 32'(lsu_fault_cause), 32'd2);
    checkOutput("to done rdata", lsu_rdata, 32'd0);
    req_ren = 0;
    cyc();
`else
    // Without the timeout the request simply keeps waiting.
    req_ren = 1; req_addr = 32'h9000; req_size = 2'd2;
    @(negedge clk); checkOutput("wait idle stall", 32'(lsu_stall), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      @(negedge clk);
      checkOutput($sformatf("wait c%0d valid", k), 32'(dmem_valid), 32'd1);
      checkOutput($sformatf("wait c%0d stall", k), 32'(lsu_stall), 32'd1);
      checkOutput($sformatf("wait c%0d fault", k), 32'(lsu_fault), 32'd0);
    end
    cyc(); dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk); checkOutput("wait last valid", 32'(dmem_valid), 32'd1);
    cyc(); dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
    @(negedge clk);
    checkOutput("wait done stall", 32'(lsu_stall), 32'd0);
    checkOutput("wait done rdata", lsu_rdata, 32'h0BADF00D);
    checkOutput("wait done cause", 32'(lsu_fault_cause), 32'd0);
    req_ren = 0;
    cyc();
`endif

    // Asynchronous reset in WAIT: outputs clear before the next edge, late response ignored.
    req_ren = 1; req_addr = 32'h8004; req_size = 2'd2; req_wdata = 32'h0;
    cyc(); dmem_ready = 1;
    cyc(); dmem_ready = 0; req_ren = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst stall", 32'(lsu_stall), 32'd0);
    checkOutput("rst valid", 32'(dmem_valid), 32'd0);
    checkOutput("rst addr", dmem_addr, 32'd0);
    checkOutput("rst wen", 32'(dmem_wen), 32'd0);
    checkOutput("rst wdata", dmem_wdata, 32'd0);
    checkOutput("rst wstrb", 32'(dmem_wstrb), 32'd0);
    checkOutput("rst rdata", lsu_rdata, 32'd0);
    checkOutput("rst fault", 32'(lsu_fault), 32'd0);
    checkOutput("rst cause", 32'(lsu_fault_cause), 32'd0);
    cyc();
    rst = 1'b0; dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("late resp stall", 32'(lsu_stall), 32'd0);
    checkOutput("late resp valid", 32'(dmem_valid), 32'd0);
    cyc(); dmem_rvalid = 0; dmem_rdata = '0;
    @(negedge clk);
    checkOutput("late resp rdata", lsu_rdata, 32'd0);
    checkOutput("late resp fault", 32'(lsu_fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine. Takes the access decoded for the instruction currently in MEM, runs one transaction on the data-memory valid/ready bus, and stalls the pipeline until the response returns. It returns right-justified load data that the MEM/WB pipeline register captures on the cycle the stall drops. Sign/zero extension is done in WB using the forwarded unsigned flag.

## Interface
- TIMEOUT_CYCLES, 256, bus-wait limit; used only with LSU_TIMEOUT_EN
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_ren  in  1  MEM-stage load
- req_wen  in  1  MEM-stage store; never asserted together with req_ren
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_flush  in  1  kill the instruction in MEM
- lsu_stall  out  1  hold IF..MEM; MEM/WB register must not advance
- lsu_rdata  out  32  load data shifted to bit 0, upper bits zero
- lsu_fault  out  1  access fault for the MEM instruction
- lsu_fault_cause  out  2  01 misaligned, 10 timeout, 00 none
- dmem_valid  out  1  request valid
- dmem_ready  in  1  request accepted
- dmem_addr  out  32  word address (req_addr with [1:0] cleared)
- dmem_wen  out  1  1 = write
- dmem_wdata  out  32  replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_rvalid  in  1  response (read data or write ack), one cycle
- dmem_rdata  in  32  read data

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: aligned (req_ren|req_wen) && !req_flush -> latch addr offset, size, wen, strobes, data; go REQ.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request; lsu_fault=1, cause=01 combinationally in IDLE; lsu_stall=0; stay IDLE.
- REQ: dmem_valid=1 with latched fields, held stable until dmem_ready. On ready go WAIT; ready && rvalid in the same cycle go directly to DONE and capture data.
- WAIT: on dmem_rvalid capture data and go DONE.
- DONE: one cycle; lsu_stall=0; lsu_rdata/lsu_fault valid; always return to IDLE. Inputs in DONE still belong to the completed instruction and are ignored.
- req_flush while in REQ or WAIT: set kill flag. The request is not withdrawn. On completion go to DRAIN/IDLE instead of DONE, and lsu_rdata is left unchanged. DRAIN is a single cycle with stall high, then IDLE.
- lsu_stall = (IDLE && aligned access && !req_flush) || REQ || WAIT || DRAIN.
- Strobes: byte 0001<<off, half 0011<<off, word 1111.
- wdata: byte replicated ×4, half ×2, word as is.
- rdata: dmem_rdata >> (8·off), masked to 8/16/32 bits by size.
- dmem_rvalid outside REQ/WAIT is ignored.

## Timing
- Reset values:
  - state IDLE
  - dmem_valid 0, dmem_wen 0, dmem_addr 0, dmem_wdata 0, dmem_wstrb 0
  - lsu_rdata 0, lsu_fault 0, lsu_fault_cause 00
  - kill flag and timeout counter 0
  - lsu_stall follows its equation (0 with no request).
- Reset mid-transaction returns to IDLE at once; a response arriving later is ignored.
- Minimum load latency, zero-wait memory (ready and rvalid in the first REQ cycle): request seen in IDLE at cycle 0, REQ at cycle 1, DONE at cycle 2. Stall is high in cycles 0–1 and low in cycle 2, and MEM/WB captures lsu_rdata at the end of cycle 2.
- Each cycle of ready delay or response delay adds one cycle.
- lsu_rdata and lsu_fault are registered and remain stable from DONE until the next DONE.
- The misaligned-fault path is combinational.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: go DONE with lsu_fault=1, cause=10, lsu_rdata=0, and dmem_valid dropped.
  - A killed transaction that times out goes to DRAIN with no fault.
- LSU_TIMEOUT_EN undefined: no counter is built; REQ/WAIT wait indefinitely; cause 10 never occurs.

## Test plan
- LW addr 0x1000, ready and rvalid the same cycle, rdata 0xDEADBEEF -> stall high 2 cycles; DONE shows lsu_rdata 0xDEADBEEF; strobe 1111 on dmem_addr 0x1000.
- LBU addr 0x1003, rdata 0x80AABBCC, 3-cycle rvalid delay -> lsu_rdata 0x00000080; stall high 5 cycles.
- SH addr 0x2002, wdata 0x00001234 -> dmem_wdata 0x12341234, strobe 1100, dmem_wen 1; dmem_valid held through 2 cycles of ready=0.
- LW addr 0x3001 -> no dmem_valid; lsu_fault 1, cause 01, stall 0 in the same cycle.
- LW in WAIT, req_flush pulsed, rvalid 2 cycles later -> DRAIN for 1 cycle; lsu_rdata unchanged; no DONE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, dmem_ready held 0 -> DONE 9 cycles after the request; cause 10, lsu_rdata 0. Also assert async reset mid-WAIT -> all outputs at reset values before the next edge.
